// File: rtl/conv_window_feeder.sv
// Raster-to-column feeder for the 3x3 convolution core: two line memories turn
// the pixel stream into vertical 3-pixel columns, with window-validity flags.
module conv_window_feeder #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned MAX_WIDTH   = 64,
    parameter int unsigned CNTW        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNTW-1:0]        cfg_width,
    input  logic [CNTW-1:0]        cfg_height,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_sof,
    input  logic                   ds_ready,
    output logic [PIXEL_WIDTH-1:0] pix_top,
    output logic [PIXEL_WIDTH-1:0] pix_mid,
    output logic [PIXEL_WIDTH-1:0] pix_bot,
    output logic                   shift_en,
    output logic                   win_valid,
    output logic                   frame_done
);

    localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [CNTW-1:0] MAX_W = CNTW'(MAX_WIDTH);
    localparam logic [CNTW-1:0] MIN_H = CNTW'(3);
    localparam logic [CNTW-1:0] ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] TWO   = CNTW'(2);

    logic [PIXEL_WIDTH-1:0] line_a [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] line_b [MAX_WIDTH];

    logic [CNTW-1:0] col_q, row_q, width_q, height_q;
    logic [CNTW-1:0] col_n, row_n, width_n, height_n;
    logic            start_q, start_n;

    logic            accept_c;
    logic            restart_c;
    logic [CNTW-1:0] cfg_w_eff_c, cfg_h_eff_c;
    logic [CNTW-1:0] col_c, row_c, width_c, height_c;
    logic            last_col_c, last_row_c;
    logic [AW-1:0]   addr_c;

    // No internal stall: the upstream sees the downstream readiness directly.
    assign s_ready  = ds_ready;
    assign accept_c = s_valid & ds_ready;

    // Clamp the configuration to the supported geometry.
    always_comb begin
        cfg_w_eff_c = cfg_width;
        cfg_h_eff_c = cfg_height;
        if ((cfg_width == '0) || (cfg_width > MAX_W)) begin
            cfg_w_eff_c = MAX_W;
        end
        if (cfg_height < MIN_H) begin
            cfg_h_eff_c = MIN_H;
        end
    end

    // Position and geometry of the pixel being accepted; a start-of-frame
    // (explicit or the first pixel after reset) forces (0,0) and fresh config.
    always_comb begin
        restart_c  = s_sof | start_q;
        col_c      = restart_c ? '0 : col_q;
        row_c      = restart_c ? '0 : row_q;
        width_c    = restart_c ? cfg_w_eff_c : width_q;
        height_c   = restart_c ? cfg_h_eff_c : height_q;
        last_col_c = (col_c == (width_c - ONE));
        last_row_c = (row_c == (height_c - ONE));
        addr_c     = AW'(col_c);
    end

    // Counter advance on acceptance.
    always_comb begin
        col_n    = col_q;
        row_n    = row_q;
        width_n  = width_q;
        height_n = height_q;
        start_n  = start_q;
        if (accept_c) begin
            start_n  = 1'b0;
            width_n  = width_c;
            height_n = height_c;
            if (last_col_c) begin
                col_n = '0;
                row_n = last_row_c ? '0 : (row_c + ONE);
            end else begin
                col_n = col_c + ONE;
                row_n = row_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            width_q    <= MAX_W;
            height_q   <= MIN_H;
            start_q    <= 1'b1;
            pix_top    <= '0;
            pix_mid    <= '0;
            pix_bot    <= '0;
            shift_en   <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            col_q      <= col_n;
            row_q      <= row_n;
            width_q    <= width_n;
            height_q   <= height_n;
            start_q    <= start_n;
            shift_en   <= accept_c;
            win_valid  <= accept_c && (row_c >= TWO) && (col_c >= TWO);
            frame_done <= accept_c && last_col_c && last_row_c;
            if (accept_c) begin
                pix_top <= line_a[addr_c];
                pix_mid <= line_b[addr_c];
                pix_bot <= s_data;
            end
        end
    end

    // Line memories are not reset; stale rows are masked by win_valid.
    always_ff @(posedge clk) begin
        if (accept_c && !rst) begin
            line_a[addr_c] <= line_b[addr_c];
            line_b[addr_c] <= s_data;
        end
    end

endmodule
